concat_packer: RTL
==================

Name: concat_packer

Overview:
- Parametrised, streaming successor to the two-operand concatenator.
- Accepts a stream of IN_W-bit fields over a valid/ready handshake and concatenates NUM consecutive fields into one IN_W*NUM-bit word. Field order is selectable: MSB-first, matching {a, b} semantics, or LSB-first.
- An early-terminate flag (in_last) flushes a partial word.
- Sits between narrow field producers and wide register/bus consumers.

Parameters:
- IN_W, 4, width of one input field in bits (>=1).
- NUM, 4, fields per output word (>=1); OUT_W = IN_W*NUM.
- MSB_FIRST, 1, 1: first accepted field occupies the top slot; 0: first field occupies bits [IN_W-1:0].

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_data  input  IN_W  field to append.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  this field terminates the current word (flush).
- in_ready  output  1  packer can accept a field this cycle.
- out_data  output  OUT_W  packed word.
- out_count  output  $clog2(NUM+1)  number of valid fields in out_data (1..NUM).
- out_valid  output  1  out_data/out_count valid.
- out_ready  input  1  consumer accepts word this cycle.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rstn.
- Reset (rstn low, takes effect immediately regardless of clk):
  - out_data=0, out_count=0, out_valid=0.
  - Accumulator=0, field counter=0, in_ready=0 while rstn low.
  - Any partial word is discarded.
- After rstn deasserts: in_ready=1 from the first cycle.
- in_ready = rstn && (!out_valid || out_ready). This is combinational, with no dependence on in_valid.
- Accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Placement of an accepted field at counter k (0-based):
  - MSB_FIRST=1: bits [OUT_W-1-k*IN_W -: IN_W].
  - MSB_FIRST=0: bits [k*IN_W +: IN_W].
- Completion: an accept with k==NUM-1 or in_last==1.
  - On the next edge, the merged word (accumulator plus this field) loads into out_data.
  - out_count = k+1; out_valid=1.
  - Accumulator and counter clear to 0.
- Non-completing accept: the field is written into the accumulator and the counter increments; out_valid is unaffected.
- Latency: out_valid rises on the clock edge that samples the completing field, i.e. visible in the following cycle.
- Partial word: unfilled slots are 0.
  - MSB_FIRST=1: the word stays left-aligned (unused low slots zero).
  - MSB_FIRST=0: unused high slots are zero.
- in_last on field NUM-1 gives one word with out_count=NUM; no extra empty word.
- Output hold: while out_valid && !out_ready:
  - out_data and out_count are stable.
  - in_ready=0, so no fields are accepted and the accumulator is frozen.
- Simultaneous completing accept and output transfer in the same cycle: the new word replaces the old one and out_valid stays 1. This gives full throughput (one field per cycle) when out_ready is held high.
- Output transfer without a new completion: out_valid clears to 0. out_data and out_count hold their last values.
- NUM=1: every accept completes. out_count is always 1; MSB_FIRST has no effect.
- in_data and in_last are ignored when the field is not accepted.
- Counter never exceeds NUM-1; there is no wrap beyond it because completion always clears it.

Test Plan:
- IN_W=4, NUM=4, MSB_FIRST=1, out_ready=1; fields 1,2,3,4 on consecutive cycles -> one cycle after the 4th accept: out_data=16'h1234, out_count=4, out_valid=1 for one cycle.
- Same stimulus with MSB_FIRST=0 -> out_data=16'h4321, out_count=4.
- MSB_FIRST=1; fields A, then B with in_last=1 -> out_data=16'hAB00, out_count=2. Next fields 5,6,7,8 -> 16'h5678, so no residue from the flushed word.
- Back-pressure:
  - Stimulus: first word complete, out_ready=0 for 5 cycles, in_valid held with field 9.
  - Required: in_ready=0 and out_data stable for all 5 cycles; after out_ready=1, field 9 is accepted.
  - Stream 8 fields with random out_ready: every word is delivered in order, with none lost or duplicated.
- Continuous stream of 12 fields 0..B with out_ready=1 -> in_ready constantly 1. Words 16'h0123, 16'h4567, 16'h89AB arrive on consecutive 4-cycle boundaries.
- Reset mid-operation:
  - Stimulus: after 2 fields accepted, pulse rstn low between clock edges.
  - Required: out_valid=0, out_data=0, out_count=0 immediately (asynchronously), without waiting for a clock edge.
  - After release, fields C,D,E,F -> 16'hCDEF, with no trace of the pre-reset fields.

Source files
------------

// File: rtl/concat_packer.sv
// Packs NUM consecutive IN_W-bit fields into one OUT_W-bit word; in_last flushes a partial word.
// Latency: the word is visible the cycle after its completing field is accepted.
// Backpressure: in_ready drops while a word is held unaccepted; a completing field may replace a word leaving the same cycle.
module concat_packer #(
    parameter int IN_W      = 4,
    parameter int NUM       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [IN_W-1:0]            in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [IN_W*NUM-1:0]        out_data,
    output logic [$clog2(NUM+1)-1:0]   out_count,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int OUT_W = IN_W * NUM;
    localparam int CNT_W = $clog2(NUM + 1);
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] merged;
    logic [IDX_W-1:0] cnt;
    logic             accept;
    logic             xfer;
    logic             last_slot;
    logic             complete;

    assign in_ready  = rstn && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign last_slot = (cnt == IDX_W'(NUM - 1));
    assign complete  = accept && (last_slot || in_last);

    // Slot s receives the field accepted at count s; other slots keep the accumulator.
    for (genvar s = 0; s < NUM; s++) begin : g_slot
        localparam int POS = (MSB_FIRST != 0) ? (NUM - 1 - s) : s;
        assign merged[POS*IN_W +: IN_W] = (cnt == IDX_W'(s)) ? in_data
                                                              : acc[POS*IN_W +: IN_W];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (complete) begin
                    out_data  <= merged;
                    out_count <= CNT_W'(cnt) + CNT_W'(1);
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= merged;
                    cnt <= cnt + IDX_W'(1);
                end
            end
            // A new word wins over the departing one, keeping back-to-back throughput.
            if (complete) begin
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
